// File: rtl/kb_ascii_tx_pkg.sv
// Shared constants for the scan-code to ASCII transmit path: FSM encoding,
// control characters and the set-2 Enter scan code.
package kb_ascii_tx_pkg;

  // 2-bit FSM state encoding
  localparam logic [1:0] ENC_IDLE    = 2'd0;
  localparam logic [1:0] ENC_XLAT    = 2'd1;
  localparam logic [1:0] ENC_SEND    = 2'd2;
  localparam logic [1:0] ENC_SEND_LF = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = ENC_IDLE,
    ST_XLAT    = ENC_XLAT,
    ST_SEND    = ENC_SEND,
    ST_SEND_LF = ENC_SEND_LF
  } state_e;

  localparam logic [7:0] ASCII_CR = 8'h0d;
  localparam logic [7:0] ASCII_LF = 8'h0a;
  localparam logic [7:0] SC_ENTER = 8'h5a;

endpackage

// File: rtl/kb_scan2ascii.sv
// Combinational set-2 scan code to ASCII ROM (lowercase letters, digits,
// space and Enter). Anything without an entry maps to UNMAPPED_CHAR.
module kb_scan2ascii
  import kb_ascii_tx_pkg::*;
#(
  parameter logic [7:0] UNMAPPED_CHAR = 8'h2a
) (
  input  logic [7:0] scan_code,
  output logic [7:0] ascii
);

  // Case-statement lookup table
  always_comb begin
    ascii = UNMAPPED_CHAR;
    case (scan_code)
      8'h1c: ascii = 8'h61; // a
      8'h32: ascii = 8'h62; // b
      8'h21: ascii = 8'h63; // c
      8'h23: ascii = 8'h64; // d
      8'h24: ascii = 8'h65; // e
      8'h2b: ascii = 8'h66; // f
      8'h34: ascii = 8'h67; // g
      8'h33: ascii = 8'h68; // h
      8'h43: ascii = 8'h69; // i
      8'h3b: ascii = 8'h6a; // j
      8'h42: ascii = 8'h6b; // k
      8'h4b: ascii = 8'h6c; // l
      8'h3a: ascii = 8'h6d; // m
      8'h31: ascii = 8'h6e; // n
      8'h44: ascii = 8'h6f; // o
      8'h4d: ascii = 8'h70; // p
      8'h15: ascii = 8'h71; // q
      8'h2d: ascii = 8'h72; // r
      8'h1b: ascii = 8'h73; // s
      8'h2c: ascii = 8'h74; // t
      8'h3c: ascii = 8'h75; // u
      8'h2a: ascii = 8'h76; // v
      8'h1d: ascii = 8'h77; // w
      8'h22: ascii = 8'h78; // x
      8'h35: ascii = 8'h79; // y
      8'h1a: ascii = 8'h7a; // z
      8'h45: ascii = 8'h30; // 0
      8'h16: ascii = 8'h31; // 1
      8'h1e: ascii = 8'h32; // 2
      8'h26: ascii = 8'h33; // 3
      8'h25: ascii = 8'h34; // 4
      8'h2e: ascii = 8'h35; // 5
      8'h36: ascii = 8'h36; // 6
      8'h3d: ascii = 8'h37; // 7
      8'h3e: ascii = 8'h38; // 8
      8'h46: ascii = 8'h39; // 9
      8'h29: ascii = 8'h20; // space
      SC_ENTER: ascii = ASCII_CR;
      default: ascii = UNMAPPED_CHAR;
    endcase
  end

endmodule

// File: rtl/kb_ascii_tx.sv
// Pops scan codes one at a time from the keyboard buffer, translates them to
// ASCII and writes them into the UART TX FIFO. Enter is sent as CR then LF.
module kb_ascii_tx
  import kb_ascii_tx_pkg::*;
#(
  parameter logic [7:0]  UNMAPPED_CHAR = 8'h2a,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             kb_buf_empty,
  input  logic [7:0]       key_code,
  output logic             rd_key_code,
  input  logic             tx_full,
  output logic             wr_tx,
  output logic [7:0]       w_data,
  output logic [CNT_W-1:0] key_cnt
);

  state_e           state_q, state_d;
  logic [7:0]       code_q, code_d;
  logic [7:0]       w_data_q, w_data_d;
  logic [CNT_W-1:0] key_cnt_q, key_cnt_d;
  logic [7:0]       lut_ascii;

  kb_scan2ascii #(
    .UNMAPPED_CHAR(UNMAPPED_CHAR)
  ) u_lut (
    .scan_code(code_q),
    .ascii    (lut_ascii)
  );

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      code_q    <= 8'h00;
      w_data_q  <= 8'h00;
      key_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      w_data_q  <= w_data_d;
      key_cnt_q <= key_cnt_d;
    end
  end

  // Next-state and strobe logic; strobes are only raised from states that
  // cannot overlap, so pop and write never coincide
  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    w_data_d    = w_data_q;
    key_cnt_d   = key_cnt_q;
    rd_key_code = 1'b0;
    wr_tx       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!kb_buf_empty) begin
          rd_key_code = 1'b1;
          code_d      = key_code;
          key_cnt_d   = key_cnt_q + CNT_W'(1);
          state_d     = ST_XLAT;
        end
      end
      ST_XLAT: begin
        w_data_d = lut_ascii;
        state_d  = ST_SEND;
      end
      ST_SEND: begin
        if (!tx_full) begin
          wr_tx = 1'b1;
          if (code_q == SC_ENTER) begin
            // Preload LF so w_data is already stable while SEND_LF waits
            w_data_d = ASCII_LF;
            state_d  = ST_SEND_LF;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_SEND_LF: begin
        if (!tx_full) begin
          wr_tx   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign w_data  = w_data_q;
  assign key_cnt = key_cnt_q;

endmodule

// File: tb/tb_kb_ascii_tx.sv
// Bench for kb_ascii_tx: a queue models the scan-code buffer, a table of
// single-key vectors checks translation and latency, and directed sequences
// cover Enter, back-pressure, reset mid-Enter and counter wrap (CNT_W=2 copy).
module tb_kb_ascii_tx;

  logic       clk;
  logic       reset;
  logic       kb_buf_empty;
  logic [7:0] key_code;
  logic       tx_full;
  logic       rd_key_code, wr_tx;
  logic [7:0] w_data;
  logic [7:0] key_cnt;
  logic       rd2, wr2;
  logic [7:0] w_data2;
  logic [1:0] key_cnt2;

  kb_ascii_tx #(.UNMAPPED_CHAR(8'h2a), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .kb_buf_empty(kb_buf_empty), .key_code(key_code),
    .rd_key_code(rd_key_code), .tx_full(tx_full), .wr_tx(wr_tx),
    .w_data(w_data), .key_cnt(key_cnt)
  );

  kb_ascii_tx #(.UNMAPPED_CHAR(8'h2a), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .kb_buf_empty(kb_buf_empty), .key_code(key_code),
    .rd_key_code(rd2), .tx_full(tx_full), .wr_tx(wr2),
    .w_data(w_data2), .key_cnt(key_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] code;
    logic [7:0] ascii;
  } vec_t;

  vec_t       vecs[12];
  logic [7:0] buf_q[$];
  logic [7:0] wr_log[$];
  int         wr_cyc[$];
  int         pop_cyc[$];
  int         cyc;
  int         rd_cnt;
  int         exp_cnt;
  int         n_cmp;
  int         n_bad;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  function automatic logic [7:0] wr_at(int i);
    if (i < wr_log.size()) return wr_log[i];
    return 8'hxx;
  endfunction

  function automatic int pop_at(int i);
    if (i < pop_cyc.size()) return pop_cyc[i];
    return -1;
  endfunction

  function automatic int wrc_at(int i);
    if (i < wr_cyc.size()) return wr_cyc[i];
    return -100;
  endfunction

  task automatic drive_buf();
    kb_buf_empty = (buf_q.size() == 0);
    key_code     = (buf_q.size() != 0) ? buf_q[0] : 8'h00;
  endtask

  // One clock: sample outputs mid-cycle, then apply the pop after the edge
  task automatic step();
    logic pop;
    @(negedge clk);
    pop = rd_key_code;
    if ((rd_key_code && wr_tx) || (rd2 && wr2)) begin
      n_bad++;
      $display("FAIL rd_wr_overlap: got rd=%0b wr=%0b, required not both", rd_key_code, wr_tx);
    end
    if (rd_key_code) begin
      rd_cnt++;
      pop_cyc.push_back(cyc);
    end
    if (wr_tx) begin
      wr_log.push_back(w_data);
      wr_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (pop && buf_q.size() != 0) void'(buf_q.pop_front());
    drive_buf();
  endtask

  task automatic run_until_wr(int n, int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (wr_log.size() >= n) break;
      step();
    end
  endtask

  task automatic clear_logs();
    wr_log.delete();
    wr_cyc.delete();
    pop_cyc.delete();
    rd_cnt = 0;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    tx_full = 1'b0;
    buf_q.delete();
    drive_buf();
    repeat (2) @(posedge clk);
    #1;
    reset   = 1'b0;
    exp_cnt = 0;
    clear_logs();
  endtask

  // Watchdog so the run always terminates
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] cnt_seq[$];
    logic [1:0] exp_seq[5];
    int         bad_hold;
    int         prev;

    vecs[0]  = '{8'h1c, 8'h61};
    vecs[1]  = '{8'h32, 8'h62};
    vecs[2]  = '{8'h43, 8'h69};
    vecs[3]  = '{8'h1a, 8'h7a};
    vecs[4]  = '{8'h45, 8'h30};
    vecs[5]  = '{8'h46, 8'h39};
    vecs[6]  = '{8'h29, 8'h20};
    vecs[7]  = '{8'h07, 8'h2a};
    vecs[8]  = '{8'h00, 8'h2a};
    vecs[9]  = '{8'hff, 8'h2a};
    vecs[10] = '{8'h3e, 8'h38};
    vecs[11] = '{8'h4d, 8'h70};
    exp_seq  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    do_reset();

    // Reset state
    check("reset_rd", {31'd0, rd_key_code}, 32'd0);
    check("reset_wr", {31'd0, wr_tx}, 32'd0);
    check("reset_w_data", {24'd0, w_data}, 32'h00);
    check("reset_key_cnt", {24'd0, key_cnt}, 32'd0);
    check("reset_key_cnt2", {30'd0, key_cnt2}, 32'd0);
    check("reset_w_data2", {24'd0, w_data2}, 32'h00);

    // Table: single keys, translation, latency, pop count, counters
    foreach (vecs[i]) begin
      clear_logs();
      buf_q.push_back(vecs[i].code);
      drive_buf();
      run_until_wr(1, 10);
      repeat (2) step();
      exp_cnt++;
      check($sformatf("vec%0d_data", i), {24'd0, wr_at(0)}, {24'd0, vecs[i].ascii});
      check($sformatf("vec%0d_nwr", i), wr_log.size(), 32'd1);
      check($sformatf("vec%0d_latency", i), wrc_at(0) - pop_at(0), 32'd2);
      check($sformatf("vec%0d_npop", i), rd_cnt, 32'd1);
      check($sformatf("vec%0d_key_cnt", i), {24'd0, key_cnt}, exp_cnt & 8'hff);
    end

    // Enter -> CR, LF with a single pop
    clear_logs();
    buf_q.push_back(8'h5a);
    drive_buf();
    run_until_wr(2, 12);
    repeat (3) step();
    check("enter_cr", {24'd0, wr_at(0)}, 32'h0d);
    check("enter_lf", {24'd0, wr_at(1)}, 32'h0a);
    check("enter_nwr", wr_log.size(), 32'd2);
    check("enter_npop", rd_cnt, 32'd1);

    // Unmapped then space, back-to-back; pops three cycles apart
    clear_logs();
    buf_q.push_back(8'h07);
    buf_q.push_back(8'h29);
    drive_buf();
    run_until_wr(2, 16);
    check("pair_first", {24'd0, wr_at(0)}, 32'h2a);
    check("pair_second", {24'd0, wr_at(1)}, 32'h20);
    check("pair_pop_spacing", pop_at(1) - pop_at(0), 32'd3);

    // Back-pressure: '0','1' queued, tx_full held for 10 cycles in SEND
    do_reset();
    clear_logs();
    tx_full = 1'b1;
    buf_q.push_back(8'h45);
    buf_q.push_back(8'h16);
    drive_buf();
    repeat (3) step();
    bad_hold = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (w_data !== 8'h30) bad_hold++;
    end
    check("stall_nwr", wr_log.size(), 32'd0);
    check("stall_w_data_bad_cycles", bad_hold, 32'd0);
    check("stall_npop", rd_cnt, 32'd1);
    check("stall_buf_left", buf_q.size(), 32'd1);
    tx_full = 1'b0;
    run_until_wr(2, 16);
    check("release_first", {24'd0, wr_at(0)}, 32'h30);
    check("release_second", {24'd0, wr_at(1)}, 32'h31);

    // Reset while waiting to send LF
    do_reset();
    buf_q.push_back(8'h5a);
    drive_buf();
    run_until_wr(1, 10);
    tx_full = 1'b1;
    repeat (2) step();
    check("midenter_nwr", wr_log.size(), 32'd1);
    check("midenter_w_data_lf", {24'd0, w_data}, 32'h0a);
    reset = 1'b1;
    #1;
    check("midreset_rd", {31'd0, rd_key_code}, 32'd0);
    check("midreset_wr", {31'd0, wr_tx}, 32'd0);
    check("midreset_w_data", {24'd0, w_data}, 32'h00);
    check("midreset_key_cnt", {24'd0, key_cnt}, 32'd0);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    tx_full = 1'b0;
    repeat (6) step();
    check("midreset_no_lf", wr_log.size(), 32'd1);

    // 2-bit counter wrap: 1,2,3,0,1
    do_reset();
    buf_q.push_back(8'h1c);
    buf_q.push_back(8'h32);
    buf_q.push_back(8'h21);
    buf_q.push_back(8'h23);
    buf_q.push_back(8'h24);
    drive_buf();
    for (int i = 0; i < 40; i++) begin
      if (cnt_seq.size() >= 5) break;
      prev = rd_cnt;
      step();
      if (rd_cnt != prev) cnt_seq.push_back(key_cnt2);
    end
    check("wrap_npop", cnt_seq.size(), 32'd5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("wrap_cnt%0d", i),
            {30'd0, (i < cnt_seq.size()) ? cnt_seq[i] : 2'bxx}, {30'd0, exp_seq[i]});
    end
    check("wrap_key_cnt8", {24'd0, key_cnt}, 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
